// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, MDU front-end hold and branch squash.
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_branch_taken,
    input  logic       ex_is_load,
    input  logic       ex_rf_wena,
    input  logic [4:0] ex_rf_waddr,
    input  logic       ex_mdu_op,
    input  logic       ex_mdu_is_div,
    output logic       pc_wena,
    output logic       if_id_wena,
    output logic       id_ex_wena,
    output logic       ex_mem_wena,
    output logic       mem_wb_wena,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mdu_start,
    output logic       mdu_busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        ST_RUN,
        ST_MDU_BUSY
    } state_e;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 2);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 2);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       load_use;

    always_comb begin
        load_use = ex_is_load & ex_rf_wena & (ex_rf_waddr != 5'd0) &
                   ((id_rs_used & (id_rs_addr == ex_rf_waddr)) |
                    (id_rt_used & (id_rt_addr == ex_rf_waddr)));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_wena      = 1'b0;
        if_id_wena   = 1'b0;
        id_ex_wena   = 1'b0;
        ex_mem_wena  = 1'b0;
        mem_wb_wena  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_start    = 1'b0;
        mdu_busy     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_mdu_op) begin
                        // Start cycle: front end frozen, EX/MEM receives bubbles until release.
                        ex_mem_wena  = 1'b1;
                        mem_wb_wena  = 1'b1;
                        ex_mem_flush = 1'b1;
                        mdu_start    = 1'b1;
                        cnt_d        = ex_mdu_is_div ? DIV_LOAD : MULT_LOAD;
                        state_d      = ST_MDU_BUSY;
                    end else if (load_use) begin
                        id_ex_wena  = 1'b1;
                        ex_mem_wena = 1'b1;
                        mem_wb_wena = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_wena     = 1'b1;
                        if_id_wena  = 1'b1;
                        id_ex_wena  = 1'b1;
                        ex_mem_wena = 1'b1;
                        mem_wb_wena = 1'b1;
                        if_id_flush = id_branch_taken;
                    end
                end
                ST_MDU_BUSY: begin
                    mdu_busy = 1'b1;
                    if (cnt_q != 5'd0) begin
                        ex_mem_wena  = 1'b1;
                        mem_wb_wena  = 1'b1;
                        ex_mem_flush = 1'b1;
                        cnt_d        = cnt_q - 5'd1;
                    end else begin
                        // Release: ex_mdu_op is still high but belongs to the finishing op.
                        pc_wena     = 1'b1;
                        if_id_wena  = 1'b1;
                        id_ex_wena  = 1'b1;
                        ex_mem_wena = 1'b1;
                        mem_wb_wena = 1'b1;
                        if_id_flush = id_branch_taken;
                        state_d     = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (!pc_wena) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage static pipeline. It drives the write-enables and flushes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also decides three things:
- when to insert load-use bubbles;
- when to hold the front end while a multi-cycle multiply/divide occupies EX;
- when to squash a wrongly fetched instruction after a taken branch/jump resolved in ID.

## Interface
Parameters:
- MULT_CYCLES, 4: total cycles a mult/multu occupies EX; must be ≥2.
- DIV_CYCLES, 32: total cycles a div/divu occupies EX; must be ≥2.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- id_rs_addr  input  5  rs field of instruction in ID.
- id_rt_addr  input  5  rt field of instruction in ID.
- id_rs_used  input  1  ID instruction reads rs.
- id_rt_used  input  1  ID instruction reads rt.
- id_branch_taken  input  1  branch/jump in ID resolved taken this cycle.
- ex_is_load  input  1  instruction in EX is a load.
- ex_rf_wena  input  1  EX instruction writes register file.
- ex_rf_waddr  input  5  EX destination register.
- ex_mdu_op  input  1  EX instruction is mult/multu/div/divu.
- ex_mdu_is_div  input  1  qualifies ex_mdu_op: 1 = divide, 0 = multiply.
- pc_wena  output  1  PC update enable.
- if_id_wena  output  1  IF/ID register write enable.
- id_ex_wena  output  1  ID/EX register write enable.
- ex_mem_wena  output  1  EX/MEM register write enable.
- mem_wb_wena  output  1  MEM/WB register write enable.
- if_id_flush  output  1  load a NOP into IF/ID at the next edge.
- id_ex_flush  output  1  load a bubble into ID/EX at the next edge.
- ex_mem_flush  output  1  load a bubble into EX/MEM at the next edge.
- mdu_start  output  1  one-cycle start pulse to the MDU.
- mdu_busy  output  1  controller is in MDU_BUSY.

## Operation
- States: RUN, MDU_BUSY. The registered state is a countdown `cnt`, 5 bits wide (holds up to DIV_CYCLES-2).
- Outputs are combinational from the state, `cnt` and the inputs.
- load_use = ex_is_load & ex_rf_wena & (ex_rf_waddr≠0) & ((id_rs_used & id_rs_addr==ex_rf_waddr) | (id_rt_used & id_rt_addr==ex_rf_waddr)).
- front_stall means: pc_wena=0, if_id_wena=0, id_ex_wena=0, ex_mem_wena=1, mem_wb_wena=1.

RUN:
- ex_mdu_op=1:
  - assert mdu_start and front_stall, and set ex_mem_flush=1.
  - load cnt ← (ex_mdu_is_div ? DIV_CYCLES : MULT_CYCLES) − 2.
  - next state MDU_BUSY.
- Else if load_use=1:
  - pc_wena=0, if_id_wena=0, id_ex_flush=1; all other enables 1.
  - No state change.
- Else:
  - all enables 1.
  - if_id_flush = id_branch_taken.

MDU_BUSY:
- mdu_busy=1.
- cnt≠0: front_stall, ex_mem_flush=1, cnt ← cnt−1.
- cnt==0 (release cycle):
  - all enables 1.
  - MDU result is written to EX/MEM.
  - if_id_flush = id_branch_taken.
  - next state RUN.
  - ex_mdu_op is still high in this cycle and must not restart the MDU.

Priority and simultaneous events:
- MDU stall overrides load_use and overrides branch flush. The branch stays in ID and is re-evaluated.
- load_use overrides branch flush. Reason: the branch operands may depend on the load.
- The flush outputs are asserted only while the corresponding register has write-enable 1.
- Back-to-back MDU ops: the second op enters EX on the release edge. The next RUN cycle then starts it normally.

## Timing
- Reset: while rst=1, all *_wena=0, all flushes=0, mdu_start=0 and mdu_busy=0. On the next edge, state ← RUN and cnt ← 0.
- Reset mid-MDU aborts the sequence. There is no pending start afterwards.
- An MDU op occupies EX for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES): the start cycle, then N−2 busy-stall cycles, then 1 release cycle. This gives N−1 front-stall cycles.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs exactly 1 squashed slot.
- mdu_start is high for exactly one cycle per MDU instruction.

## Configuration
- STALL_PERF_CNT_EN defined:
  - adds output port stall_cnt, output, 32 bits.
  - stall_cnt increments on every non-reset cycle where pc_wena=0.
  - reset value 0; wraps from 0xFFFFFFFF to 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Load-use: lw $2 in EX, ID reads rs=$2 with id_rs_used=1 → one cycle of pc_wena=0, if_id_wena=0, id_ex_flush=1; the next cycle has all enables 1.
- Load to $0: ex_rf_waddr=0 with a matching ID read → no stall.
- div in EX with DIV_CYCLES=32:
  - mdu_start pulses once.
  - pc_wena=0 for 31 consecutive cycles, and ex_mem_flush=1 in those same 31 cycles.
  - mem_wb_wena=1 throughout.
  - release on cycle 32.
- mult followed immediately by div:
  - starts two cycles apart from the mult release, i.e. release then start.
  - total front stalls 3+31 with MULT_CYCLES=4.
- id_branch_taken=1 during MDU_BUSY (cnt≠0) → if_id_flush=0. The flush is asserted only in the release cycle if still taken.
- rst asserted in MDU_BUSY with cnt=10:
  - all enables 0 during reset.
  - after deassert: RUN, mdu_busy=0, all enables 1.
  - stall_cnt=0 when STALL_PERF_CNT_EN is defined.
